tt_um_islam_ihfaz_latch_writer: RTL

Clocked write sequencer: the driving end of the D/enable latch interface. It takes a byte and writes it bit by bit into an external bank of eight transparent D-latches. For each bit it presents the data on a shared D line, pulses the enable line, and drives a 3-bit latch select, with programmable setup, pulse and hold windows. It sits in the same TinyTapeout tile wrapper as our latch designs and drives their `d`/`e` pins.

---
 rtl/latch_writer_pkg.sv | 22 ++
 rtl/latch_writer_sync2.sv | 24 ++
 rtl/tt_um_islam_ihfaz_latch_writer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/latch_writer_pkg.sv
// latch_writer_pkg: shared state encoding, pin indices and counter width for the latch writer.
package latch_writer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int PIN_START = 0;
    localparam int PIN_ABORT = 1;
    localparam int PIN_RB    = 2;
    localparam int PIN_D     = 0;
    localparam int PIN_E     = 1;
    localparam int PIN_SEL   = 2;
    localparam int PIN_BUSY  = 5;
    localparam int PIN_DONE  = 6;
    localparam int PIN_ERR   = 7;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/latch_writer_sync2.sv
// latch_writer_sync2: two-flop synchronizer for one asynchronous pin, cleared to 0 by reset.
module latch_writer_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/tt_um_islam_ihfaz_latch_writer.sv
// tt_um_islam_ihfaz_latch_writer: writes a byte bit by bit into eight external D-latches via d/e/select.
// Optional readback compare of the written bit is built when LATCH_WRITER_READBACK_EN is defined.
module tt_um_islam_ihfaz_latch_writer
    import latch_writer_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CNT_W-1:0] LD_S = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_P = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_H = CNT_W'(HOLD_CYC - 1);

    logic             w_start_s;
    logic             w_abort_s;
    logic             w_accept;
    logic             w_err;
    logic             r_start_q;
    logic             r_start_rise;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_byte;
    logic             r_d;
    logic             r_e;
    logic             r_busy;
    logic             r_done;

    latch_writer_sync2 u_sync_start (.clk(clk), .rst_n(rst_n), .i_d(ui_in[PIN_START]), .o_q(w_start_s));
    latch_writer_sync2 u_sync_abort (.clk(clk), .rst_n(rst_n), .i_d(ui_in[PIN_ABORT]), .o_q(w_abort_s));

    // abort has priority over a start edge seen in the same cycle
    assign w_accept = (r_state == IDLE) && r_start_rise && !w_abort_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_q    <= 1'b0;
            r_start_rise <= 1'b0;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_byte       <= '0;
            r_d          <= 1'b0;
            r_e          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_start_q    <= w_start_s;
            r_start_rise <= w_start_s & ~r_start_q;
            if (w_abort_s && r_state != IDLE) begin
                r_state <= IDLE;
                r_e     <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_idx   <= '0;
            end else begin
                case (r_state)
                    IDLE: if (w_accept) begin
                        r_byte  <= uio_in;
                        r_idx   <= '0;
                        r_d     <= uio_in[0];
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= LD_S;
                        r_state <= SETUP;
                    end
                    SETUP: if (r_cnt == '0) begin
                        r_state <= STROBE;
                        r_e     <= 1'b1;
                        r_cnt   <= LD_P;
                    end else r_cnt <= r_cnt - CNT_W'(1);
                    STROBE: if (r_cnt == '0) begin
                        r_state <= HOLD;
                        r_e     <= 1'b0;
                        r_cnt   <= LD_H;
                    end else r_cnt <= r_cnt - CNT_W'(1);
                    HOLD: if (r_cnt == '0) begin
                        if (r_idx == 3'd7) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_d     <= r_byte[r_idx + 3'd1];
                            r_cnt   <= LD_S;
                            r_state <= SETUP;
                        end
                    end else r_cnt <= r_cnt - CNT_W'(1);
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef LATCH_WRITER_READBACK_EN
    logic w_rb_s;
    logic r_err;

    // two sync flops delay q, so it is only trustworthy this late after e rises
    if (PULSE_CYC + HOLD_CYC < 3) begin : g_rb_check
        $error("LATCH_WRITER_READBACK_EN needs PULSE_CYC + HOLD_CYC >= 3");
    end

    latch_writer_sync2 u_sync_rb (.clk(clk), .rst_n(rst_n), .i_d(ui_in[PIN_RB]), .o_q(w_rb_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else if (w_accept) r_err <= 1'b0;
        else if (r_state == HOLD && r_cnt == '0 && !w_abort_s && w_rb_s != r_d) r_err <= 1'b1;
    end

    assign w_err = r_err;

    logic w_unused;
    assign w_unused = &{1'b0, ena, ui_in[7:3]};
`else
    assign w_err = 1'b0;

    logic w_unused;
    assign w_unused = &{1'b0, ena, ui_in[7:2]};
`endif

    assign uo_out  = {w_err, r_done, r_busy, r_idx, r_e, r_d};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
